// File: rtl/match_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// match_scoreboard_pkg : FSM state encoding and scoring helper functions
// Rev 1.0
// ============================================================================
package match_scoreboard_pkg;

  localparam int c_MAX_PLAYERS = 8;
  localparam int c_MAX_SCORE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PLAY       = 2'd1,
    ST_GAME_OVER  = 2'd2,
    ST_MATCH_OVER = 2'd3
  } state_t;

  typedef logic [c_MAX_PLAYERS-1:0][c_MAX_SCORE_W-1:0] score_vec_t;

  function automatic logic [2:0] lowest_set(input logic [c_MAX_PLAYERS-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = c_MAX_PLAYERS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Unused player slots are zero, so they never win the max.
  function automatic logic [c_MAX_SCORE_W-1:0] max_excluding(input score_vec_t s,
                                                             input logic [2:0] skip);
    logic [c_MAX_SCORE_W-1:0] m;
    m = '0;
    for (int i = 0; i < c_MAX_PLAYERS; i++) begin
      if (3'(i) != skip && s[i] > m) m = s[i];
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/match_scoreboard_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : per-player point counter, saturates at all-ones, clr wins
// Rev 1.0
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/match_scoreboard.sv
`default_nettype none
// ============================================================================
// match_scoreboard : N-player point/game/match tracker with win-by-margin rule
// Rev 1.0
// ============================================================================
module match_scoreboard
  import match_scoreboard_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 5,
  parameter int WIN_SCORE    = 11,
  parameter int WIN_BY       = 2,
  parameter int GAMES_TO_WIN = 2,
  parameter int GAME_W       = 2
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic                                                  next_game,
  input  logic [NUM_PLAYERS-1:0]                                scored,
  output logic [NUM_PLAYERS*SCORE_W-1:0]                        score,
  output logic [NUM_PLAYERS*GAME_W-1:0]                         games,
  output logic                                                  game_over,
  output logic                                                  match_over,
  output logic [((NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1)-1:0] winner,
  output logic                                                  conflict
);

  localparam int c_WIN_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

  state_t                                r_state;
  logic [NUM_PLAYERS-1:0][GAME_W-1:0]    r_games;
  logic [c_WIN_W-1:0]                    r_winner;
  logic                                  r_game_over;
  logic                                  r_match_over;
  logic                                  r_conflict;

  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   w_count;
  logic [c_MAX_PLAYERS-1:0]              w_scored_ext;
  logic [2:0]                            w_idx;
  logic [c_WIN_W-1:0]                    w_p;
  logic                                  w_any;
  logic                                  w_multi;
  logic                                  w_play_step;
  logic                                  w_clr;
  score_vec_t                            w_score_ext;
  logic [SCORE_W-1:0]                    w_cur;
  logic [SCORE_W-1:0]                    w_new;
  logic [c_MAX_SCORE_W-1:0]              w_other_max;
  logic [31:0]                           w_new32;
  logic [31:0]                           w_max32;
  logic                                  w_win;
  logic [GAME_W-1:0]                     w_games_next;

  assign w_scored_ext = c_MAX_PLAYERS'(scored);
  assign w_idx        = lowest_set(w_scored_ext);
  assign w_p          = w_idx[c_WIN_W-1:0];
  assign w_any        = |scored;
  assign w_multi      = (scored & (scored - NUM_PLAYERS'(1))) != '0;
  assign w_play_step  = (r_state == ST_PLAY) && !start && w_any;
  assign w_clr        = start || ((r_state == ST_GAME_OVER) && next_game);

  generate
    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
      sat_counter #(.WIDTH(SCORE_W)) u_points (
        .clk   (clk),
        .reset (reset),
        .inc   (w_play_step && (w_idx == 3'(i))),
        .clr   (w_clr),
        .count (w_count[i])
      );
    end
  endgenerate

  always_comb begin
    w_score_ext = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_score_ext[i] = c_MAX_SCORE_W'(w_count[i]);
    end
  end

  // Win is judged on the post-increment score of the credited player only.
  assign w_cur        = w_count[w_p];
  assign w_new        = (w_cur == c_SCORE_MAX) ? w_cur : w_cur + SCORE_W'(1);
  assign w_other_max  = max_excluding(w_score_ext, w_idx);
  assign w_new32      = 32'(w_new);
  assign w_max32      = 32'(w_other_max);
  assign w_win        = w_play_step &&
                        (((w_new32 >= 32'(WIN_SCORE)) && (w_new32 >= w_max32 + 32'(WIN_BY))) ||
                         (w_new == c_SCORE_MAX));
  assign w_games_next = r_games[w_p] + GAME_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_games      <= '0;
      r_winner     <= '0;
      r_game_over  <= 1'b0;
      r_match_over <= 1'b0;
      r_conflict   <= 1'b0;
    end else begin
      r_conflict <= 1'b0;
      if (start) begin
        r_state      <= ST_PLAY;
        r_games      <= '0;
        r_winner     <= '0;
        r_game_over  <= 1'b0;
        r_match_over <= 1'b0;
      end else begin
        case (r_state)
          ST_PLAY: begin
            if (w_any) begin
              r_conflict <= w_multi;
              if (w_win) begin
                r_winner       <= w_p;
                r_games[w_p]   <= w_games_next;
                r_game_over    <= 1'b1;
                if (w_games_next == GAME_W'(GAMES_TO_WIN)) begin
                  r_state      <= ST_MATCH_OVER;
                  r_match_over <= 1'b1;
                end else begin
                  r_state      <= ST_GAME_OVER;
                end
              end
            end
          end
          ST_GAME_OVER: begin
            if (next_game) begin
              r_state     <= ST_PLAY;
              r_game_over <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign score      = w_count;
  assign games      = r_games;
  assign game_over  = r_game_over;
  assign match_over = r_match_over;
  assign winner     = r_winner;
  assign conflict   = r_conflict;

endmodule
`default_nettype wire
